// File: rtl/fetch_stage_pkg.sv
// Shared fetch-path types: redirect select, fetch request FSM states and the IF->ID payload.
package rv32imc_types;

  typedef enum logic {
    pc_next   = 1'b0,
    pc_offset = 1'b1
  } pc_mux_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] order;
  } if_stage_t;

  localparam logic [3:0] RMASK_WORD = 4'hF;
  localparam logic [3:0] RMASK_NONE = 4'h0;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO holding fetched {pc, inst} pairs; clear beats push and pop.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (count_o == CW'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: fetch PC, single-outstanding imem request FSM, instruction queue to decode.
module fetch_stage
  import rv32imc_types::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h1eceb000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  pc_mux_t     i_pc_mux,
  input  logic [31:0] i_pc_offset,
  input  logic        i_flush,
  input  logic        if_stall,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output if_stage_t   if_stage_reg
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t state_q;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q;
  logic [63:0]  order_q, order_d;
  logic         issued_q;

  logic          issue, push, pop;
  logic [63:0]   q_head;
  logic          q_full, q_empty;
  logic [CW-1:0] q_count;

  // Only IDLE may issue, so queue occupancy alone bounds queue + outstanding.
  assign issue = !rst && (state_q == IDLE) && !i_flush && (q_count < CW'(QUEUE_DEPTH));
  assign push  = (state_q == WAIT) && imem_resp && !i_flush;
  assign pop   = !q_empty && !if_stall && !i_flush;

  assign imem_rmask = issue ? RMASK_WORD : RMASK_NONE;
  assign imem_addr  = (state_q == IDLE) ? fetch_pc_q : req_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (i_flush)   fetch_pc_d = i_pc_offset;
    else if (push) fetch_pc_d = req_pc_q + 32'd4;
  end

  assign order_d = order_q + 64'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      order_q    <= '0;
      issued_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      order_q    <= order_d;
      if (issue) begin
        req_pc_q <= fetch_pc_q;
        issued_q <= 1'b1;
      end
      case (state_q)
        IDLE: if (issue) state_q <= WAIT;
        // A redirect racing the response still retires the request, just without its data.
        WAIT: begin
          if (i_flush)        state_q <= imem_resp ? IDLE : DROP;
          else if (imem_resp) state_q <= IDLE;
        end
        DROP: if (imem_resp) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (64)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .clear_i (i_flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({req_pc_q, imem_rdata}),
    .rdata_o (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  always_comb begin
    if_stage_reg = '0;
    if (!q_empty) begin
      if_stage_reg.valid = 1'b1;
      if_stage_reg.pc    = q_head[63:32];
      if_stage_reg.inst  = q_head[31:0];
      if_stage_reg.order = order_q;
    end
  end

  a_flush_qualifies_mux: assert property (@(posedge clk) disable iff (rst)
    i_flush == (i_pc_mux == pc_offset));

  a_no_resp_in_idle: assert property (@(posedge clk) disable iff (rst)
    !(imem_resp && (state_q == IDLE) && issued_q));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && q_full && !pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized + directed bench for fetch_stage against a queue-level fetch model.
module tb_fetch_stage;
  import rv32imc_types::*;

  localparam logic [31:0] RPC = 32'h1eceb000;
  localparam int          QD  = 2;

  logic        clk, rst;
  pc_mux_t     i_pc_mux;
  logic [31:0] i_pc_offset;
  logic        i_flush, if_stall;
  logic [31:0] imem_addr, imem_rdata;
  logic [3:0]  imem_rmask;
  logic        imem_resp;
  if_stage_t   if_stage_reg;

  fetch_stage #(.RESET_PC(RPC), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst(rst), .i_pc_mux(i_pc_mux), .i_pc_offset(i_pc_offset),
    .i_flush(i_flush), .if_stall(if_stall), .imem_addr(imem_addr),
    .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .if_stage_reg(if_stage_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: fetch pc, one outstanding request (busy/stale), instruction queue, pop count.
  logic [31:0] m_pc, m_req;
  bit          m_busy, m_stale;
  logic [63:0] m_q[$];
  logic [63:0] m_order;

  // Memory responder.
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_lo, lat_hi, p_flush, p_stall;

  logic [3:0]  last_rmask;
  logic [31:0] last_addr, last_pc;
  logic        last_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_flush = 1'b0; i_pc_mux = pc_next; i_pc_offset = '0;
    if_stall = 1'b0; imem_resp = 1'b0; imem_rdata = '0;
    @(negedge clk);
    #1;
    chk("rst_rmask", 64'(imem_rmask), 64'h0);
    chk("rst_addr", 64'(imem_addr), 64'(RPC));
    chk("rst_valid", 64'(if_stage_reg.valid), 64'h0);
    chk("rst_pc", 64'(if_stage_reg.pc), 64'h0);
    chk("rst_inst", 64'(if_stage_reg.inst), 64'h0);
    chk("rst_order", if_stage_reg.order, 64'h0);
    m_pc = RPC; m_req = RPC; m_busy = 0; m_stale = 0; m_q.delete(); m_order = '0;
    mem_busy = 0; mem_cnt = 0; mem_addr = '0;
  endtask

  // fl_mode / st_mode: -1 random, 0 deasserted, 1 asserted.
  task automatic step(input int fl_mode, input logic [31:0] tgt_in, input int st_mode);
    logic fl, st, rsp, exp_issue;
    logic [31:0] tgt, rd;
    @(negedge clk);
    rst = 1'b0;
    fl  = (fl_mode < 0) ? ($urandom_range(99) < p_flush) : (fl_mode != 0);
    st  = (st_mode < 0) ? ($urandom_range(99) < p_stall) : (st_mode != 0);
    if (fl_mode < 0) tgt = ($urandom_range(7) == 0) ? 32'hFFFFFFF8 : ($urandom() & 32'hFFFFFFFC);
    else             tgt = tgt_in;
    rsp = mem_busy && (mem_cnt == 1);
    rd  = rsp ? mem_word(mem_addr) : $urandom();
    i_flush     = fl;
    i_pc_mux    = fl ? pc_offset : pc_next;
    i_pc_offset = fl ? tgt : ($urandom() & 32'hFFFFFFFC);
    if_stall    = st;
    imem_resp   = rsp;
    imem_rdata  = rd;
    #1;
    exp_issue = !m_busy && !fl && (m_q.size() < QD);
    chk("rmask", 64'(imem_rmask), exp_issue ? 64'hF : 64'h0);
    chk("addr", 64'(imem_addr), 64'(m_busy ? m_req : m_pc));
    chk("valid", 64'(if_stage_reg.valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("head_pc", 64'(if_stage_reg.pc), 64'(m_q[0][63:32]));
      chk("head_inst", 64'(if_stage_reg.inst), 64'(m_q[0][31:0]));
      chk("head_order", if_stage_reg.order, m_order);
    end
    last_rmask = imem_rmask; last_addr = imem_addr;
    last_valid = if_stage_reg.valid; last_pc = if_stage_reg.pc;
    if (fl) begin
      m_pc = tgt;
      m_q.delete();
      if (m_busy) begin
        if (rsp) begin m_busy = 0; m_stale = 0; end
        else m_stale = 1;
      end
    end else begin
      if (m_q.size() > 0 && !st) begin
        void'(m_q.pop_front());
        m_order++;
      end
      if (m_busy && rsp) begin
        if (!m_stale) begin
          m_q.push_back({m_req, rd});
          m_pc = m_req + 32'd4;
        end
        m_busy = 0; m_stale = 0;
      end else if (exp_issue) begin
        m_busy = 1; m_stale = 0; m_req = m_pc;
      end
    end
    if (rsp) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (imem_rmask == 4'hF) begin
      mem_busy = 1; mem_addr = imem_addr; mem_cnt = $urandom_range(lat_hi, lat_lo);
    end
  endtask

  initial begin
    int n_iss;
    bit found;
    rst = 1'b1;
    lat_lo = 1; lat_hi = 1; p_flush = 0; p_stall = 0;

    // Back-to-back fetch with 1-cycle memory.
    do_reset();
    for (int i = 0; i < 12; i++) step(0, '0, 0);

    // Stall holds: exactly two requests fill the queue, then fetch halts.
    do_reset();
    n_iss = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, '0, 1);
      if (last_rmask == 4'hF) n_iss++;
    end
    chk("stall_issues", 64'(n_iss), 64'd2);
    for (int i = 0; i < 10; i++) step(0, '0, 0);

    // Redirect while waiting on ..008.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_busy && m_req == RPC + 32'h8 && !(mem_busy && mem_cnt == 1)) found = 1;
      else step(0, '0, 0);
    end
    chk("wait008_reached", 64'(found), 64'h1);
    step(1, RPC + 32'h100, 0);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(0, '0, 0);
      if (last_rmask == 4'hF) begin
        found = 1;
        chk("redir_addr", 64'(last_addr), 64'(RPC + 32'h100));
      end
    end
    chk("redir_issued", 64'(found), 64'h1);
    for (int i = 0; i < 6; i++) step(0, '0, 0);

    // Redirect coincident with a response.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 3; i++) step(0, '0, 0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_busy && mem_cnt == 1) found = 1;
      else step(0, '0, 0);
    end
    step(1, RPC + 32'h200, 0);
    step(0, '0, 0);
    chk("coinc_issue", 64'(last_rmask), 64'hF);
    chk("coinc_addr", 64'(last_addr), 64'(RPC + 32'h200));
    chk("coinc_valid", 64'(last_valid), 64'h0);

    // Redirect with full queue under stall: target valid three cycles later.
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_q.size() == QD && !m_busy) found = 1;
      else step(0, '0, 1);
    end
    chk("fullq_reached", 64'(found), 64'h1);
    step(1, RPC + 32'h300, 1);
    step(0, '0, 1);
    chk("fq_v1", 64'(last_valid), 64'h0);
    step(0, '0, 1);
    chk("fq_v2", 64'(last_valid), 64'h0);
    step(0, '0, 1);
    chk("fq_v3", 64'(last_valid), 64'h1);
    chk("fq_pc", 64'(last_pc), 64'(RPC + 32'h300));

    // Wrap past 2^32 with 3-cycle memory.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    step(1, 32'hFFFFFFFC, 0);
    n_iss = 0;
    for (int i = 0; i < 20 && n_iss < 2; i++) begin
      step(0, '0, 0);
      if (last_rmask == 4'hF) begin
        n_iss++;
        chk(n_iss == 1 ? "wrap_first" : "wrap_next", 64'(last_addr),
            n_iss == 1 ? 64'hFFFFFFFC : 64'h0);
      end
    end
    chk("wrap_issues", 64'(n_iss), 64'd2);

    // Randomized phases.
    do_reset();
    lat_lo = 1; lat_hi = 4; p_flush = 5;  p_stall = 30;
    for (int i = 0; i < 500; i++) step(-1, '0, -1);
    lat_lo = 1; lat_hi = 1; p_flush = 2;  p_stall = 70;
    for (int i = 0; i < 500; i++) step(-1, '0, -1);
    lat_lo = 2; lat_hi = 6; p_flush = 15; p_stall = 10;
    for (int i = 0; i < 500; i++) step(-1, '0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
